// File: rtl/riscv_pkg.sv
// Shared core types and constants used by the memory port arbiter.
package riscv_pkg;
    localparam int XLEN           = 32;
    localparam int MAX_STARVE_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RSP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } arb_owner_t;
endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive LS wins taken while an IF request was waiting.
module arb_starve_cnt #(
    parameter int MAX = riscv_pkg::MAX_STARVE_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !at_max)
            cnt <= cnt + 1'b1;
    end

    assign at_max = (cnt == W'(MAX));
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one
// transaction outstanding, LS priority with a starvation bound for IF.
module mem_port_arbiter #(
    parameter int XLEN       = riscv_pkg::XLEN,
    parameter int MAX_STARVE = riscv_pkg::MAX_STARVE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_i,
    input  logic [XLEN-1:0]   if_adr_i,
    input  logic              if_kill_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [XLEN-1:0]   ls_adr_i,
    input  logic [XLEN-1:0]   ls_wdata_i,
    input  logic [XLEN/8-1:0] ls_be_i,
    output logic              ls_gnt_o,
    output logic              ls_rvalid_o,
    output logic [XLEN-1:0]   ls_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN-1:0]   mem_adr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [XLEN/8-1:0] mem_be_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i
);
    import riscv_pkg::*;

    arb_state_t state, state_nxt;
    arb_owner_t owner;
    logic       killed;
    logic       if_pend, any_req, ls_wins, arb;
    logic       starve_inc, starve_clr, starve_at_max;

    // A fetch that is being flushed in the same cycle never competes.
    assign if_pend    = if_req_i && !if_kill_i;
    assign any_req    = ls_req_i || if_pend;
    assign ls_wins    = ls_req_i && !(if_pend && starve_at_max);
    assign arb        = (state == IDLE) && any_req;
    assign starve_inc = arb && ls_wins && if_pend;
    assign starve_clr = arb && !ls_wins;

    arb_starve_cnt #(.MAX(MAX_STARVE)) u_starve (
        .clk    (clk),
        .reset  (reset),
        .inc    (starve_inc),
        .clr    (starve_clr),
        .at_max (starve_at_max)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= OWN_LS;
            killed      <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_adr_o   <= '0;
            mem_wdata_o <= '0;
            mem_be_o    <= '0;
        end else begin
            state <= state_nxt;
            if (arb) begin
                mem_req_o <= 1'b1;
                killed    <= 1'b0;
                if (ls_wins) begin
                    owner       <= OWN_LS;
                    mem_we_o    <= ls_we_i;
                    mem_adr_o   <= ls_adr_i;
                    mem_wdata_o <= ls_wdata_i;
                    mem_be_o    <= ls_be_i;
                end else begin
                    owner       <= OWN_IF;
                    mem_we_o    <= 1'b0;
                    mem_adr_o   <= if_adr_i;
                    mem_wdata_o <= '0;
                    mem_be_o    <= '1;
                end
            end
            if (state == WAIT_GNT && mem_gnt_i)
                mem_req_o <= 1'b0;
            // The memory handshake always completes; a flush only marks the response as dead.
            if (state != IDLE && owner == OWN_IF && if_kill_i)
                killed <= 1'b1;
            if (state == WAIT_RSP && mem_rvalid_i)
                killed <= 1'b0;
        end
    end

    always_comb begin
        state_nxt   = state;
        if_gnt_o    = 1'b0;
        ls_gnt_o    = 1'b0;
        if_rvalid_o = 1'b0;
        ls_rvalid_o = 1'b0;
        case (state)
            IDLE:     if (any_req) state_nxt = WAIT_GNT;
            WAIT_GNT: begin
                if_gnt_o = mem_gnt_i && (owner == OWN_IF);
                ls_gnt_o = mem_gnt_i && (owner == OWN_LS);
                if (mem_gnt_i) state_nxt = WAIT_RSP;
            end
            WAIT_RSP: begin
                if_rvalid_o = mem_rvalid_i && (owner == OWN_IF) && !killed && !if_kill_i;
                ls_rvalid_o = mem_rvalid_i && (owner == OWN_LS);
                if (mem_rvalid_i) state_nxt = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
        if_rdata_o = if_rvalid_o ? mem_rdata_i[31:0] : '0;
        ls_rdata_o = ls_rvalid_o ? mem_rdata_i : '0;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a bench-side memory responder, a
// transaction-level reference model checked every cycle, and literal checks.
module tb_mem_port_arbiter;
    localparam int XLEN = 32;
    localparam int MAX  = 4;

    logic clk = 1'b0;
    logic reset;
    logic if_req_i, if_kill_i, if_gnt_o, if_rvalid_o;
    logic [31:0] if_adr_i, if_rdata_o;
    logic ls_req_i, ls_we_i, ls_gnt_o, ls_rvalid_o;
    logic [31:0] ls_adr_i, ls_wdata_i, ls_rdata_o;
    logic [3:0]  ls_be_i;
    logic mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_adr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_be_o;

    mem_port_arbiter #(.XLEN(XLEN), .MAX_STARVE(MAX)) dut (
        .clk(clk), .reset(reset),
        .if_req_i(if_req_i), .if_adr_i(if_adr_i), .if_kill_i(if_kill_i),
        .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_adr_i(ls_adr_i),
        .ls_wdata_i(ls_wdata_i), .ls_be_i(ls_be_i),
        .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_adr_o(mem_adr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    int tests = 0, failed = 0;
    int cyc = 0;
    bit started = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        tests++;
        failed++;
        $display("FAIL %s: timed out, DUT event never seen (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        case (a)
            32'h100: return 32'h0000_0013;
            32'h200: return 32'hDEAD_BEEF;
            default: return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    // ---------------- memory responder ----------------
    int gnt_delay = 0, rsp_delay = 1;
    bit spur = 0;
    initial begin
        int wcnt, rcnt;
        logic [31:0] rdat;
        wcnt = 0; rcnt = 0; rdat = '0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
        forever begin
            @(posedge clk); #1;
            mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
            if (reset) rcnt = 0;
            if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin mem_rvalid_i = 1; mem_rdata_i = rdat; end
            end else if (spur) begin
                mem_rvalid_i = 1; mem_rdata_i = 32'h0BAD_F00D; spur = 0;
            end
            if (mem_req_o) begin
                if (wcnt >= gnt_delay) begin
                    mem_gnt_i = 1; wcnt = 0; rcnt = rsp_delay;
                    rdat = mem_we_o ? 32'h5555_AAAA : mem_data(mem_adr_o);
                end else wcnt++;
            end else wcnt = 0;
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    int m_phase = 0;            // 0 idle, 1 request posted, 2 awaiting response
    bit m_if = 0, m_killed = 0, m_we = 0;
    int m_starve = 0;
    logic [31:0] m_adr = '0, m_wdata = '0;
    logic [3:0]  m_be = '0;

    int if_rv_cnt = 0, ls_rv_cnt = 0, if_rv_cyc = 0, req_cycles = 0;
    logic [31:0] last_if_rdata, last_ls_rdata, gnt_adr, gnt_wdata;
    logic [3:0]  gnt_be;
    logic        gnt_we;
    bit gnt_log[$];             // 1 = IF grant, 0 = LS grant

    always @(negedge clk) begin
        bit e_ifv, e_lsv, if_p;
        cyc++;
        if (started) begin
            e_ifv = (m_phase == 2) && mem_rvalid_i && m_if && !m_killed && !if_kill_i;
            e_lsv = (m_phase == 2) && mem_rvalid_i && !m_if;
            chk("mem_req", mem_req_o, m_phase == 1);
            chk("if_gnt", if_gnt_o, (m_phase == 1) && mem_gnt_i && m_if);
            chk("ls_gnt", ls_gnt_o, (m_phase == 1) && mem_gnt_i && !m_if);
            chk("if_rvalid", if_rvalid_o, e_ifv);
            chk("ls_rvalid", ls_rvalid_o, e_lsv);
            if (m_phase == 1) begin
                chk("mem_we", mem_we_o, m_we);
                chk("mem_adr", mem_adr_o, m_adr);
                chk("mem_wdata", mem_wdata_o, m_wdata);
                chk("mem_be", mem_be_o, m_be);
            end
            if (e_ifv) chk("if_rdata", if_rdata_o, mem_rdata_i);
            if (e_lsv) chk("ls_rdata", ls_rdata_o, mem_rdata_i);

            if (mem_req_o) req_cycles++;
            if (if_gnt_o) gnt_log.push_back(1'b1);
            if (ls_gnt_o) gnt_log.push_back(1'b0);
            if (mem_req_o && mem_gnt_i) begin
                gnt_adr = mem_adr_o; gnt_wdata = mem_wdata_o; gnt_be = mem_be_o; gnt_we = mem_we_o;
            end
            if (if_rvalid_o) begin if_rv_cnt++; last_if_rdata = if_rdata_o; if_rv_cyc = cyc; end
            if (ls_rvalid_o) begin ls_rv_cnt++; last_ls_rdata = ls_rdata_o; end

            if (reset) begin
                m_phase = 0; m_if = 0; m_killed = 0; m_starve = 0;
            end else if (m_phase == 0) begin
                if_p = if_req_i && !if_kill_i;
                m_killed = 0;
                if (ls_req_i && !(if_p && m_starve == MAX)) begin
                    m_if = 0; m_we = ls_we_i; m_adr = ls_adr_i; m_wdata = ls_wdata_i; m_be = ls_be_i;
                    if (if_p && m_starve < MAX) m_starve++;
                    m_phase = 1;
                end else if (if_p) begin
                    m_if = 1; m_we = 0; m_adr = if_adr_i; m_wdata = '0; m_be = 4'hF;
                    m_starve = 0;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (if_kill_i && m_if) m_killed = 1;
                if (mem_gnt_i) m_phase = 2;
            end else begin
                if (mem_rvalid_i) begin m_phase = 0; m_killed = 0; end
                else if (if_kill_i && m_if) m_killed = 1;
            end
        end
    end

    // ---------------- stimulus helpers (entered/left at posedge+1) ----------------
    task automatic if_xact(input logic [31:0] adr);
        int n = 0;
        if_req_i = 1; if_adr_i = adr;
        do begin @(negedge clk); n++; end while (!if_gnt_o && n < 200);
        if (!if_gnt_o) timeout("if_gnt_wait");
        @(posedge clk); #1;
        if_req_i = 0;
    endtask

    task automatic ls_xact(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                           input logic [3:0] be);
        int n = 0;
        ls_req_i = 1; ls_we_i = we; ls_adr_i = adr; ls_wdata_i = wd; ls_be_i = be;
        do begin @(negedge clk); n++; end while (!ls_gnt_o && n < 200);
        if (!ls_gnt_o) timeout("ls_gnt_wait");
        @(posedge clk); #1;
        ls_req_i = 0;
    endtask

    task automatic wait_rv(input int ift, input int lst, input string nm);
        int n = 0;
        while ((if_rv_cnt < ift || ls_rv_cnt < lst) && n < 200) begin @(negedge clk); n++; end
        if (if_rv_cnt < ift || ls_rv_cnt < lst) timeout(nm);
        @(posedge clk); #1;
    endtask

    task automatic clear_obs();
        if_rv_cnt = 0; ls_rv_cnt = 0; req_cycles = 0;
        gnt_log.delete();
    endtask

    initial begin
        int req_cyc, n;
        reset = 1; if_req_i = 0; if_adr_i = '0; if_kill_i = 0;
        ls_req_i = 0; ls_we_i = 0; ls_adr_i = '0; ls_wdata_i = '0; ls_be_i = '0;
        @(posedge clk); #1;
        started = 1;
        @(negedge clk);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_mem_adr", mem_adr_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        chk("rst_mem_be", mem_be_o, 0);
        chk("rst_gnts", {if_gnt_o, ls_gnt_o, if_rvalid_o, ls_rvalid_o}, 0);
        chk("rst_rdata", if_rdata_o | ls_rdata_o, 0);
        @(posedge clk); #1;
        reset = 0;

        // IF only: grant one cycle after mem_req, response the next cycle
        gnt_delay = 1; rsp_delay = 1; clear_obs();
        req_cyc = cyc + 1;
        if_xact(32'h100);
        wait_rv(1, 0, "if_only_rsp");
        chk("if_only_adr", gnt_adr, 32'h100);
        chk("if_only_be", gnt_be, 4'hF);
        chk("if_only_we", gnt_we, 0);
        chk("if_only_rdata", last_if_rdata, 32'h0000_0013);
        chk("if_only_latency", if_rv_cyc - req_cyc, 3);
        chk("if_only_ngnt", gnt_log.size(), 1);

        // simultaneous LS load and IF: LS first, no cross-routing
        gnt_delay = 0; clear_obs();
        fork
            if_xact(32'h300);
            ls_xact(1'b0, 32'h400, 32'h0, 4'hF);
        join
        wait_rv(1, 1, "simul_rsp");
        chk("simul_ngnt", gnt_log.size(), 2);
        if (gnt_log.size() == 2) begin
            chk("simul_first_ls", gnt_log[0], 0);
            chk("simul_second_if", gnt_log[1], 1);
        end
        chk("simul_if_rdata", last_if_rdata, mem_data(32'h300));
        chk("simul_ls_rdata", last_ls_rdata, mem_data(32'h400));

        // starvation: both hammering, expect LLLL I LLLL I
        clear_obs();
        fork
            for (int i = 0; i < 8; i++) ls_xact(1'b0, 32'h1000 + i * 4, 32'h0, 4'hF);
            for (int j = 0; j < 2; j++) if_xact(32'h2000 + j * 4);
        join
        wait_rv(2, 8, "starve_rsp");
        chk("starve_ngnt", gnt_log.size(), 10);
        if (gnt_log.size() == 10)
            for (int k = 0; k < 10; k++)
                chk($sformatf("starve_order_%0d", k), gnt_log[k], (k == 4 || k == 9));

        // kill while the IF response is outstanding
        rsp_delay = 3; clear_obs();
        if_xact(32'h200);
        if_kill_i = 1;
        @(posedge clk); #1;
        if_kill_i = 0;
        repeat (6) begin @(posedge clk); #1; end
        chk("kill_no_rvalid", if_rv_cnt, 0);
        chk("kill_gnt_pulsed", gnt_log.size(), 1);
        rsp_delay = 1;
        if_xact(32'h104);
        wait_rv(1, 0, "kill_recover_rsp");
        chk("kill_recover_rdata", last_if_rdata, mem_data(32'h104));

        // store with the grant held off for 5 cycles
        gnt_delay = 5; clear_obs();
        ls_xact(1'b1, 32'h500, 32'hCAFE_F00D, 4'b0110);
        wait_rv(0, 1, "store_ack");
        chk("store_req_cycles", req_cycles, 6);
        chk("store_we", gnt_we, 1);
        chk("store_be", gnt_be, 4'b0110);
        chk("store_wdata", gnt_wdata, 32'hCAFE_F00D);
        chk("store_adr", gnt_adr, 32'h500);
        chk("store_ls_gnt", (gnt_log.size() == 1) && !gnt_log[0], 1);

        // reset while waiting for a grant, then a stray response
        gnt_delay = 20; clear_obs();
        ls_req_i = 1; ls_we_i = 0; ls_adr_i = 32'h600; ls_be_i = 4'hF;
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_req_o && n < 50);
        if (!mem_req_o) timeout("rst_mid_req");
        @(posedge clk); #1;
        reset = 1; ls_req_i = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_mem_req", mem_req_o, 0);
        chk("rst_mid_mem_fields", {mem_we_o, mem_be_o} | mem_adr_o | mem_wdata_o, 0);
        chk("rst_mid_hs", {if_gnt_o, ls_gnt_o, if_rvalid_o, ls_rvalid_o}, 0);
        @(posedge clk); #1;
        reset = 0; spur = 1;
        repeat (4) begin @(posedge clk); #1; end
        chk("spur_no_rvalid", if_rv_cnt + ls_rv_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, failed);
        $fatal(1);
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single core memory port between the instruction-fetch stage (IF) and the load/store unit (LS).
- One transaction is outstanding at a time. LS has priority over IF, with a bounded starvation limit for IF.
- A fetch flush kills an in-flight IF transaction: the memory handshake still completes, but the response is dropped.
- Sits between ifetch/LSU and the memory/icache interface.

Parameters:
- XLEN, 32 (riscv_pkg::XLEN): address/data width.
- MAX_STARVE, 4: consecutive LS wins over a pending IF request before IF is forced to win.

Ports:
- clk  input  1  core clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- if_req_i  input  1  fetch request; held with if_adr_i stable until if_gnt_o
- if_adr_i  input  XLEN  fetch address
- if_kill_i  input  1  flush: discard the outstanding/pending IF response
- if_gnt_o  output  1  IF request accepted by memory (1-cycle pulse)
- if_rvalid_o  output  1  IF read data valid (1-cycle pulse)
- if_rdata_o  output  32  instruction word
- ls_req_i  input  1  LS request; held with address/data stable until ls_gnt_o
- ls_we_i  input  1  1 = store, 0 = load
- ls_adr_i  input  XLEN  LS address
- ls_wdata_i  input  XLEN  store data
- ls_be_i  input  XLEN/8  byte enables
- ls_gnt_o  output  1  LS request accepted (1-cycle pulse)
- ls_rvalid_o  output  1  LS response valid: load data, or store ack
- ls_rdata_o  output  XLEN  load data
- mem_req_o  output  1  memory request (registered)
- mem_we_o  output  1  write enable
- mem_adr_o  output  XLEN  address
- mem_wdata_o  output  XLEN  write data
- mem_be_o  output  XLEN/8  byte enables; all ones for IF
- mem_gnt_i  input  1  memory accepts the request this cycle
- mem_rvalid_i  input  1  response valid; earliest the cycle after mem_gnt_i
- mem_rdata_i  input  XLEN  response data

Behaviour:
- Reset values:
  - state = IDLE; mem_req_o/we/adr/wdata/be = 0.
  - All gnt/rvalid outputs = 0; rdata outputs = 0 via gating.
  - starve_cnt = 0; owner = LS; killed = 0.
- FSM states: IDLE, WAIT_GNT, WAIT_RSP.
- IDLE:
  - If any request is pending, arbitrate and register the winner's address, we, wdata and be into the mem_* outputs. Set mem_req_o=1 and go to WAIT_GNT.
  - Arbitration at cycle N gives mem_req_o high from N+1.
  - An if_req_i that is simultaneous with if_kill_i is not arbitrated.
- Arbitration rules:
  - LS wins if ls_req_i && !(if_req_i && starve_cnt==MAX_STARVE); otherwise IF wins.
  - starve_cnt increments (saturating at MAX_STARVE) when LS wins while if_req_i=1.
  - starve_cnt clears when IF wins.
- WAIT_GNT:
  - mem_* outputs are held stable until mem_gnt_i.
  - On mem_gnt_i: drop mem_req_o, pulse the owner's gnt_o in the same cycle (combinational from mem_gnt_i & owner), go to WAIT_RSP.
- WAIT_RSP:
  - On mem_rvalid_i: owner rvalid_o = mem_rvalid_i (combinational); rdata_o = mem_rdata_i gated by owner. Go to IDLE.
  - The earliest next arbitration is the following cycle, so the minimum period is 3 cycles per transaction with zero-wait memory.
- Kill:
  - if_kill_i while owner=IF in WAIT_GNT or WAIT_RSP sets killed.
  - The request is never retracted: mem_req_o is held until grant.
  - if_gnt_o is still pulsed.
  - if_rvalid_o is suppressed for that response; killed clears on return to IDLE.
  - if_kill_i with owner=LS has no effect.
- Stores: the store still waits for mem_rvalid_i, which is delivered as ls_rvalid_o with data ignored.
- Spurious response: mem_rvalid_i in IDLE or WAIT_GNT is ignored, and no rvalid_o is asserted.
- Mid-operation reset: returns to IDLE the next edge and drops mem_req_o. A response arriving after reset is ignored under the spurious-response rule.
- Guarantee: gnt_o and rvalid_o are never asserted for the non-owner.

Decomposition:
- riscv_pkg:
  - arb_state_t enum (IDLE, WAIT_GNT, WAIT_RSP).
  - arb_owner_t enum (OWN_IF, OWN_LS).
  - Default MAX_STARVE constant.
- Sub-module: arb_starve_cnt (saturating counter with inc/clr/at_max). Everything else stays flat.

Test Plan:
- IF only:
  - Stimulus: if_req_i=1, adr=0x100; mem_gnt_i in the cycle after mem_req_o; mem_rvalid_i next cycle with rdata=0x00000013.
  - Response: mem_adr_o=0x100, be=0xF; if_gnt_o pulses; if_rvalid_o pulses with if_rdata_o=0x00000013 three cycles after the request.
- Simultaneous LS load + IF:
  - Response: LS served first. IF is served on the next arbitration and receives its data; no cross-routing.
- Starvation (MAX_STARVE=4):
  - Stimulus: LS and IF continuously requesting.
  - Response: 4 LS transactions, then 1 IF, then starve_cnt=0 and LS again.
- Kill in WAIT_RSP:
  - Stimulus: if_kill_i asserted one cycle after if_gnt_o; response rdata=0xDEADBEEF.
  - Response: if_rvalid_o stays 0; FSM back to IDLE.
- Store with mem_gnt_i delayed 5 cycles:
  - Response: mem_* stable all 5 cycles with we=1 and be=ls_be_i; ls_gnt_o pulses at grant; ls_rvalid_o pulses on the ack.
- Reset asserted in WAIT_GNT:
  - Stimulus: then mem_rvalid_i pulsed after reset.
  - Response: mem_req_o=0 the next cycle, all outputs at reset values, no rvalid_o.
